hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Hazard and stall controller that drives the hold/advance control of the IF/ID pipeline register (IF_ID_Write), the PC write enable, and the ID/EX control-bubble mux.
- Detects load-use hazards, flushes IF/ID on taken branches, and freezes the front end for a fixed-latency multiply/divide.
- Sits in the ID stage beside the register file. It is the producer of every stall and flush the IF/ID register consumes.

Parameters:
- MD_LATENCY, 4, front-end freeze cycles after a mul/div issues (legal range 1..15).
- STALL_CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- ID_EX_MemRead  input  1  instruction in EX is a load.
- ID_EX_Rt  input  5  destination register of that load.
- IF_ID_Rs  input  5  source register rs of instruction in ID.
- IF_ID_Rt  input  5  source register rt of instruction in ID.
- Branch_Taken  input  1  branch in ID resolved taken this cycle.
- MD_Start  input  1  instruction in ID is mul/div.
- IF_ID_Write  output  1  0 = IF/ID loads, 1 = IF/ID holds (stall).
- PC_Write  output  1  1 = PC updates, 0 = PC holds.
- Control_Bubble  output  1  1 = zero the control word entering ID/EX.
- IF_ID_Flush  output  1  1 = IF/ID loads a NOP (0x00000000) next edge.
- MD_Busy  output  1  high while in MD_WAIT.
- Stall_Count  output  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- States: RUN and MD_WAIT. There is a 4-bit down-counter md_cnt.
- While rst is high:
  - State is RUN and md_cnt = 0.
  - IF_ID_Write=1, PC_Write=0, Control_Bubble=1, IF_ID_Flush=0, MD_Busy=0, Stall_Count=0.
- When rst deasserts, the block is in RUN. Outputs come from the RUN rules on the first cycle.
- load_use = ID_EX_MemRead & (ID_EX_Rt != 0) & (ID_EX_Rt == IF_ID_Rs | ID_EX_Rt == IF_ID_Rt).
- RUN outputs are combinational (same cycle) and evaluated in priority order:
  1. load_use: IF_ID_Write=1, PC_Write=0, Control_Bubble=1, IF_ID_Flush=0. Branch_Taken and MD_Start are ignored this cycle. Stays in RUN; the stall naturally lasts 1 cycle.
  2. Branch_Taken: IF_ID_Write=0, PC_Write=1, Control_Bubble=0, IF_ID_Flush=1. MD_Start is ignored.
  3. MD_Start: normal advance (IF_ID_Write=0, PC_Write=1, Control_Bubble=0, IF_ID_Flush=0). At the edge, go to MD_WAIT with md_cnt = MD_LATENCY-1.
  4. Otherwise: normal advance.
- MD_WAIT:
  - Outputs: IF_ID_Write=1, PC_Write=0, Control_Bubble=1, IF_ID_Flush=0, MD_Busy=1. All hazard inputs are ignored.
  - Each edge: if md_cnt==0, return to RUN; otherwise md_cnt decrements.
  - Duration is exactly MD_LATENCY cycles.
- IF_ID_Flush and IF_ID_Write=1 are never asserted together.
- Reset during MD_WAIT aborts the wait immediately (async) and returns to RUN.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined: Stall_Count increments by 1 on every posedge where IF_ID_Write==1 (sampled after reset release). It saturates at all-ones and is cleared only by rst.
- Undefined: no counter flops are built and Stall_Count is tied to 0.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_Rt=5, IF_ID_Rs=5 -> that cycle IF_ID_Write=1, PC_Write=0, Control_Bubble=1. With ID_EX_MemRead=0 the next cycle -> normal advance resumes.
- Register $zero and non-match:
  - ID_EX_Rt=0, IF_ID_Rs=0, MemRead=1 -> no stall.
  - ID_EX_Rt=7, IF_ID_Rs=3, IF_ID_Rt=4 -> no stall.
- Branch vs load-use:
  - Branch_Taken=1 alone -> IF_ID_Flush=1, PC_Write=1.
  - Branch_Taken=1 together with load_use -> IF_ID_Flush=0, IF_ID_Write=1.
- Mul/div with MD_LATENCY=4: MD_Start=1 one cycle -> MD_Busy=1 and IF_ID_Write=1 for exactly 4 following cycles, then IF_ID_Write=0. Branch_Taken=1 during MD_WAIT -> no flush.
- Reset mid-wait: assert rst 2 cycles into MD_WAIT between edges -> MD_Busy=0 immediately; after release, RUN behaviour with md_cnt=0.
- Perf counter (STALL_PERF_CNT_EN defined): 1 load-use stall + 1 MD op of 4 cycles -> Stall_Count=5. With STALL_CNT_W=2, 6 stall cycles -> Stall_Count=3 (saturated).

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the IF/ID register, PC enable and ID/EX bubble mux.
// Define STALL_PERF_CNT_EN to build the saturating stall-cycle performance counter.
module hazard_stall_ctrl #(
    parameter int MD_LATENCY  = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ID_EX_MemRead,
    input  logic [4:0]             ID_EX_Rt,
    input  logic [4:0]             IF_ID_Rs,
    input  logic [4:0]             IF_ID_Rt,
    input  logic                   Branch_Taken,
    input  logic                   MD_Start,
    output logic                   IF_ID_Write,
    output logic                   PC_Write,
    output logic                   Control_Bubble,
    output logic                   IF_ID_Flush,
    output logic                   MD_Busy,
    output logic [STALL_CNT_W-1:0] Stall_Count
);

    typedef enum logic {RUN, MD_WAIT} state_t;

    localparam logic [3:0] MD_RELOAD = 4'(MD_LATENCY - 1);

    state_t     state, state_nxt;
    logic [3:0] md_cnt, md_cnt_nxt;
    logic       load_use;

    // Register $zero is never a real dependency, so it cannot cause a stall.
    assign load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                      ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            md_cnt <= 4'd0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        case (state)
            RUN: begin
                if (!load_use && !Branch_Taken && MD_Start) begin
                    state_nxt  = MD_WAIT;
                    md_cnt_nxt = MD_RELOAD;
                end
            end
            MD_WAIT: begin
                if (md_cnt == 4'd0) begin
                    state_nxt = RUN;
                end else begin
                    md_cnt_nxt = md_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt  = RUN;
                md_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Reset holds the front end frozen; otherwise priority is load-use, branch, advance.
    always_comb begin
        IF_ID_Write    = 1'b0;
        PC_Write       = 1'b1;
        Control_Bubble = 1'b0;
        IF_ID_Flush    = 1'b0;
        MD_Busy        = 1'b0;
        if (rst) begin
            IF_ID_Write    = 1'b1;
            PC_Write       = 1'b0;
            Control_Bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        IF_ID_Write    = 1'b1;
                        PC_Write       = 1'b0;
                        Control_Bubble = 1'b1;
                    end else if (Branch_Taken) begin
                        IF_ID_Flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    IF_ID_Write    = 1'b1;
                    PC_Write       = 1'b0;
                    Control_Bubble = 1'b1;
                    MD_Busy        = 1'b1;
                end
                default: begin
                    IF_ID_Write    = 1'b1;
                    PC_Write       = 1'b0;
                    Control_Bubble = 1'b1;
                end
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (IF_ID_Write && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign Stall_Count = stall_cnt;
`else
    assign Stall_Count = '0;
`endif

endmodule
